pixel_to_ram: RTL and testbench
===============================

PIXEL_TO_RAM -- requirements
Module: pixel_to_ram

Interface
REQ-001 Parameter H_ACTIVE, default 480, meaning active pixels per line.
REQ-002 Parameter V_ACTIVE, default 272, meaning active lines per frame.
REQ-003 Parameter ADDR_W, default 17, meaning frame-buffer address width.
REQ-004 clk_i  input  1  single clock; all logic on posedge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 en_i  input  1  capture enable, sampled only at an accepted start-of-frame pixel.
REQ-007 pix_valid_i  input  1  pixel present.
REQ-008 pix_ready_o  output  1  pixel accepted when valid and ready are both high.
REQ-009 pix_sof_i  input  1  marks the first pixel of a frame.
REQ-010 pix_eol_i  input  1  marks the last pixel of a line.
REQ-011 pix_r_i, pix_g_i, pix_b_i  input  5/6/5  pixel colour fields.
REQ-012 ram_wr_en_o  output  1  frame-buffer write strobe.
REQ-013 ram_wr_addr_o  output  ADDR_W  frame-buffer write address.
REQ-014 ram_wr_data_o  output  16  packed pixel, {b[15:11], g[10:5], r[4:0]}.
REQ-015 frame_done_o  output  1  one-cycle pulse on the final write of a complete frame.
REQ-016 frame_cnt_o  output  8  count of completed frames.
REQ-017 err_sof_o, err_line_o  output  1 each  sticky error flags.
REQ-018 err_clr_i  input  1  clears both sticky error flags.

Function
REQ-019 FSM states are IDLE, WRITE and DONE.
REQ-020 IDLE: pix_ready_o=1; non-sof pixels are discarded without writes; an accepted sof with en_i=1 goes to WRITE and writes that pixel to address 0; an accepted sof with en_i=0 stays in IDLE.
REQ-021 WRITE: pix_ready_o=1; every accepted pixel is written to address y*H_ACTIVE+x; x increments, and x wraps to 0 with y+1 after x=H_ACTIVE-1 or after an accepted eol.
REQ-022 Write latency is one cycle: a pixel accepted at edge N drives ram_wr_en_o=1 with its address and data during cycle N+1; otherwise ram_wr_en_o=0.
REQ-023 Acceptance of pixel (H_ACTIVE-1, V_ACTIVE-1) goes to DONE; frame_done_o is asserted in the same cycle as that write; frame_cnt_o increments, wrapping 255->0.
REQ-024 DONE: pix_ready_o=0 for exactly one cycle, then the FSM goes to IDLE.
REQ-025 An accepted sof in WRITE at any position other than (0,0) sets err_sof_o, restarts the frame at address 0 with that pixel, and produces no frame_done_o for the abandoned frame.
REQ-026 An accepted eol with x!=H_ACTIVE-1, or an accepted pixel at x=H_ACTIVE-1 without eol, sets err_line_o; the counters still realign per REQ-021.
REQ-027 err_clr_i clears both flags on the next edge; if a set and a clear occur in the same cycle, the set wins.
REQ-028 en_i changes during WRITE have no effect on the frame in progress.
REQ-029 The maximum address (H_ACTIVE*V_ACTIVE-1 = 130559) must fit in ADDR_W; addresses never exceed it.

Reset
REQ-030 rst_i=1 at any edge forces IDLE, x=y=0, and the following outputs: ram_wr_en_o=0, ram_wr_addr_o=0, ram_wr_data_o=0, frame_done_o=0, frame_cnt_o=0, err_sof_o=0, err_line_o=0.
REQ-031 pix_ready_o is 0 while rst_i=1 and 1 in the cycle after reset releases.
REQ-032 After a mid-frame reset, no write occurs until the next accepted sof with en_i=1.

Structure
REQ-033 A shared package holds H_ACTIVE/V_ACTIVE defaults (480/272, also used by the LCD reader), FB_ADDR_W=17, PIX_W=16, the FSM state encoding, and the RGB565 packing order.
REQ-034 One sub-module, pixel_coord_counter, holds x/y counters, wrap/eol logic and the linear address.

Verification
REQ-035 Full frame of 130560 pixels, sof first, eol every 480, en_i=1 -> 130560 writes at addresses 0..130559, one frame_done_o, frame_cnt_o=1, no errors.
REQ-036 Pixel r=5'h1F, g=0, b=0 at (0,1) -> write at address 480 with data 16'h001F.
REQ-037 sof at pixel 1000 of a frame -> err_sof_o=1, next write at address 0, no frame_done_o; the following full frame completes normally.
REQ-038 eol at x=100 on line 3 -> err_line_o=1, next pixel written to address 4*480=1920; err_clr_i pulse -> err_line_o=0.
REQ-039 Random pix_valid_i gaps plus en_i=0 at the first sof -> no writes for that frame; the second frame with en_i=1 is written completely; ready is low only for one DONE cycle.
REQ-040 rst_i pulse at pixel 50000 -> all outputs reset; non-sof pixels are discarded; the next sof frame completes with frame_cnt_o=1.

Source files
------------

// File: rtl/pixel_to_ram_pkg.sv
// Shared definitions for the camera capture path and the LCD reader.
// Latency: n/a (types, constants and a packing helper only).
// Backpressure: n/a.
package pixel_to_ram_pkg;

    // Panel geometry. The LCD reader scans the same frame buffer, so it uses these too.
    localparam int H_ACTIVE_DEF = 480;
    localparam int V_ACTIVE_DEF = 272;

    // Frame-buffer geometry: 480*272 = 130560 words fit in 17 address bits.
    localparam int FB_ADDR_W = 17;
    localparam int PIX_W     = 16;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } cap_state_t;

    // RGB565 word as stored in the frame buffer: blue in the MSBs, red in the LSBs.
    typedef struct packed {
        logic [B_W-1:0] b;
        logic [G_W-1:0] g;
        logic [R_W-1:0] r;
    } rgb565_t;

    function automatic logic [PIX_W-1:0] pack_rgb565(
        input logic [R_W-1:0] r,
        input logic [G_W-1:0] g,
        input logic [B_W-1:0] b
    );
        rgb565_t p;
        p.b = b;
        p.g = g;
        p.r = r;
        return p;
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Tracks the (x, y) position of the next pixel of a frame and its linear frame-buffer address.
// Latency: address is combinational from the current position; the position updates on the step edge.
// Backpressure: none; the caller asserts i_step only for pixels it actually writes.
//
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset (position -> 0,0)
//   i_start        current pixel starts a frame: treat the position as (0,0)
//   i_step         current pixel is written: advance past it
//   i_eol          current pixel carries end-of-line
//   o_addr         y*H_ACTIVE + x of the current pixel
//   o_at_origin    stored position is (0,0), i.e. nothing written yet in this frame
//   o_last_pix     current pixel is the final pixel of the frame
//   o_line_err     eol and the last-column position disagree for the current pixel
module pixel_coord_counter
    import pixel_to_ram_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_eol,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_at_origin,
    output logic              o_last_pix,
    output logic              o_line_err
);

    localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] w_cx;
    logic [Y_W-1:0] w_cy;
    logic [X_W-1:0] w_x_nxt;
    logic [Y_W-1:0] w_y_nxt;
    logic           w_last_col;
    logic           w_wrap;

    always_comb begin
        // A start-of-frame pixel always lands at (0,0), wherever the counters were.
        w_cx        = i_start ? '0 : r_x;
        w_cy        = i_start ? '0 : r_y;
        w_last_col  = (w_cx == X_LAST);
        w_wrap      = w_last_col || i_eol;
        o_at_origin = (r_x == '0) && (r_y == '0);
        o_last_pix  = w_last_col && (w_cy == Y_LAST);
        o_line_err  = i_eol != w_last_col;
        o_addr      = ADDR_W'(w_cy) * ADDR_W'(H_ACTIVE) + ADDR_W'(w_cx);

        w_x_nxt = w_wrap ? '0 : w_cx + X_W'(1);
        // An early eol on the last line folds back to line 0 so the address can
        // never run past the end of the buffer.
        if (!w_wrap) begin
            w_y_nxt = w_cy;
        end else if (w_cy == Y_LAST) begin
            w_y_nxt = '0;
        end else begin
            w_y_nxt = w_cy + Y_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
        end
    end

endmodule

// File: rtl/pixel_to_ram.sv
// Captures a pixel stream (RGB565 with sof/eol markers) into a linear frame buffer.
// Latency: a pixel accepted at edge N is written (en/addr/data) during cycle N+1.
// Backpressure: ready is high except during reset and the single cycle after a frame completes.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   en_i                         capture enable, looked at only on an accepted sof in IDLE
//   pix_valid_i / pix_ready_o    pixel handshake
//   pix_sof_i, pix_eol_i         frame / line markers
//   pix_r_i, pix_g_i, pix_b_i    5/6/5 colour fields
//   ram_wr_en_o/addr_o/data_o    frame-buffer write port
//   frame_done_o, frame_cnt_o    completion pulse and completed-frame counter
//   err_sof_o, err_line_o        sticky framing errors, cleared by err_clr_i
module pixel_to_ram
    import pixel_to_ram_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    input  logic              pix_sof_i,
    input  logic              pix_eol_i,
    input  logic [R_W-1:0]    pix_r_i,
    input  logic [G_W-1:0]    pix_g_i,
    input  logic [B_W-1:0]    pix_b_i,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_wr_addr_o,
    output logic [PIX_W-1:0]  ram_wr_data_o,
    output logic              frame_done_o,
    output logic [7:0]        frame_cnt_o,
    output logic              err_sof_o,
    output logic              err_line_o,
    input  logic              err_clr_i
);

    cap_state_t        r_state;
    cap_state_t        w_state_nxt;

    logic              w_accept;
    logic              w_capture;
    logic              w_start;
    logic              w_sof_err;
    logic              w_line_err_set;
    logic              w_frame_end;

    logic [ADDR_W-1:0] w_addr;
    logic              w_at_origin;
    logic              w_last_pix;
    logic              w_line_err;

    pixel_coord_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_coord (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_start     (w_start),
        .i_step      (w_capture),
        .i_eol       (pix_eol_i),
        .o_addr      (w_addr),
        .o_at_origin (w_at_origin),
        .o_last_pix  (w_last_pix),
        .o_line_err  (w_line_err)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = w_last_pix ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_frame_end) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output / control decode.
    always_comb begin
        // Ready drops combinationally with reset so nothing is taken while it is held.
        pix_ready_o = !rst_i && (r_state != ST_DONE);
        w_accept    = pix_valid_i && pix_ready_o;
        // In IDLE only an enabled sof begins a capture; in WRITE every accepted pixel
        // is written, and en_i is ignored so a frame in progress is never cut short.
        w_capture   = w_accept &&
                      (((r_state == ST_IDLE) && pix_sof_i && en_i) || (r_state == ST_WRITE));
        w_start     = w_capture && pix_sof_i;
        // A sof at the origin of a running frame is not an error: nothing was abandoned.
        w_sof_err      = w_start && (r_state == ST_WRITE) && !w_at_origin;
        w_line_err_set = w_capture && w_line_err;
        w_frame_end    = w_capture && w_last_pix;
    end

    // Registered write port, counters and sticky flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_wr_en_o   <= 1'b0;
            ram_wr_addr_o <= '0;
            ram_wr_data_o <= '0;
            frame_done_o  <= 1'b0;
            frame_cnt_o   <= 8'd0;
            err_sof_o     <= 1'b0;
            err_line_o    <= 1'b0;
        end else begin
            ram_wr_en_o  <= w_capture;
            frame_done_o <= w_frame_end;
            if (w_capture) begin
                ram_wr_addr_o <= w_addr;
                ram_wr_data_o <= pack_rgb565(pix_r_i, pix_g_i, pix_b_i);
            end
            if (w_frame_end) begin
                frame_cnt_o <= frame_cnt_o + 8'd1;
            end
            // A new error in the same cycle as a clear keeps the flag set.
            if (w_sof_err) begin
                err_sof_o <= 1'b1;
            end else if (err_clr_i) begin
                err_sof_o <= 1'b0;
            end
            if (w_line_err_set) begin
                err_line_o <= 1'b1;
            end else if (err_clr_i) begin
                err_line_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_to_ram.sv
// Directed-plus-random bench for pixel_to_ram on a reduced 16x6 panel.
// Latency: n/a.
// Backpressure: pixels are held valid until the reference model says they were taken.
module tb_pixel_to_ram;

    localparam int H  = 16;
    localparam int V  = 6;
    localparam int AW = 8;
    localparam int N  = H * V;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        valid;
    logic        sof;
    logic        eol;
    logic        clr;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;

    wire          ready;
    wire          wr_en;
    wire [AW-1:0] addr;
    wire [15:0]   data;
    wire          done;
    wire [7:0]    cnt;
    wire          err_sof;
    wire          err_line;

    pixel_to_ram #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .pix_valid_i   (valid),
        .pix_ready_o   (ready),
        .pix_sof_i     (sof),
        .pix_eol_i     (eol),
        .pix_r_i       (r),
        .pix_g_i       (g),
        .pix_b_i       (b),
        .ram_wr_en_o   (wr_en),
        .ram_wr_addr_o (addr),
        .ram_wr_data_o (data),
        .frame_done_o  (done),
        .frame_cnt_o   (cnt),
        .err_sof_o     (err_sof),
        .err_line_o    (err_line),
        .err_clr_i     (clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: "capturing" flag, position of the next pixel, one-cycle gap after a frame.
    bit          m_cap   = 0;
    bit          m_gap   = 0;
    int          m_x     = 0;
    int          m_y     = 0;
    logic [7:0]  m_cnt   = 0;
    bit          m_esof  = 0;
    bit          m_eline = 0;
    bit          m_acc   = 0;
    logic        e_wr    = 0;
    logic        e_done  = 0;
    logic [AW-1:0] e_addr = 0;
    logic [15:0] e_data  = 0;

    int n_wr   = 0;
    int n_done = 0;
    int n_nrdy = 0;
    int gap_pct = 0;
    bit en_rand = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input bit s, input bit e,
                              input logic [4:0] rr, input logic [5:0] gg, input logic [4:0] bb);
        bit rdy;
        bit set_s;
        bit set_l;
        m_acc  = 0;
        e_wr   = 0;
        e_done = 0;
        set_s  = 0;
        set_l  = 0;
        if (rst) begin
            m_cap = 0; m_gap = 0; m_x = 0; m_y = 0; m_cnt = 0;
            m_esof = 0; m_eline = 0; e_addr = 0; e_data = 0;
        end else begin
            rdy   = !m_gap;
            m_gap = 0;
            if (v && rdy) begin
                m_acc = 1;
                if (s && (m_cap || en)) begin
                    if (m_cap && (m_x != 0 || m_y != 0)) set_s = 1;
                    m_cap = 1;
                    m_x   = 0;
                    m_y   = 0;
                end
                if (m_cap) begin
                    e_wr   = 1;
                    e_addr = AW'(m_y * H + m_x);
                    e_data = {bb, gg, rr};
                    if (e != (m_x == H - 1)) set_l = 1;
                    if (m_x == H - 1 && m_y == V - 1) begin
                        e_done = 1;
                        m_cap  = 0;
                        m_gap  = 1;
                        m_cnt  = m_cnt + 8'd1;
                    end
                    if (m_x == H - 1 || e) begin
                        m_x = 0;
                        m_y = (m_y + 1) % V;
                    end else begin
                        m_x = m_x + 1;
                    end
                end
            end
            m_esof  = set_s ? 1'b1 : (clr ? 1'b0 : m_esof);
            m_eline = set_l ? 1'b1 : (clr ? 1'b0 : m_eline);
        end
    endtask

    // One clock: drive inputs after the falling edge, check ready, update model on the
    // rising edge, check registered outputs on the next falling edge.
    task automatic tick(input bit v, input bit s, input bit e,
                        input logic [4:0] rr, input logic [5:0] gg, input logic [4:0] bb);
        valid = v; sof = s; eol = e; r = rr; g = gg; b = bb;
        #1;
        chk("ready", ready, (!rst && !m_gap));
        if (ready === 1'b0 && !rst) n_nrdy++;
        @(posedge clk);
        model_edge(v, s, e, rr, gg, bb);
        @(negedge clk);
        chk("wr_en", wr_en, e_wr);
        if (e_wr || rst) begin
            chk("wr_addr", addr, e_addr);
            chk("wr_data", data, e_data);
        end
        chk("frame_done", done, e_done);
        chk("frame_cnt", cnt, m_cnt);
        chk("err_sof", err_sof, m_esof);
        chk("err_line", err_line, m_eline);
        if (wr_en === 1'b1) n_wr++;
        if (done === 1'b1) n_done++;
    endtask

    task automatic idle_tick();
        tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
    endtask

    task automatic send_pix(input bit s, input bit e,
                            input logic [4:0] rr, input logic [5:0] gg, input logic [4:0] bb);
        int k;
        for (k = 0; k < 20 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct; k++) idle_tick();
        m_acc = 0;
        for (k = 0; k < 8 && !m_acc; k++) tick(1, s, e, rr, gg, bb);
        chk("accept_bound", m_acc, 1);
    endtask

    // Sends pixels with linear indices start_idx.. with eol on the last column.
    task automatic send_seq(input int start_idx, input int count, input bit sof_first);
        for (int k = 0; k < count; k++) begin
            int idx;
            idx = start_idx + k;
            if (en_rand && k > 0) en = 1'($urandom_range(0, 1));
            send_pix(sof_first && k == 0, (idx % H) == H - 1,
                     5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        int w0;
        int d0;
        int nr0;
        rst = 1; en = 0; valid = 0; sof = 0; eol = 0; clr = 0; r = 0; g = 0; b = 0;

        // Reset values and ready held low during reset.
        repeat (3) idle_tick();
        chk("rst_ready", ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cnt", cnt, 0);
        rst = 0;
        idle_tick();
        chk("ready_after_rst", ready, 1);

        // Non-sof pixels in IDLE are dropped.
        en = 1;
        w0 = n_wr;
        send_seq(3, 5, 0);
        chk("idle_discard", n_wr - w0, 0);

        // Complete frame.
        w0 = n_wr; d0 = n_done;
        send_seq(0, N, 1);
        idle_tick();
        chk("full_writes", n_wr - w0, N);
        chk("full_done", n_done - d0, 1);
        chk("full_cnt", cnt, 1);
        chk("full_no_err", {err_sof, err_line}, 0);

        // Pure red at (0,1).
        send_seq(0, H, 1);
        send_pix(0, 0, 5'h1F, 6'h00, 5'h00);
        chk("red_addr", addr, H);
        chk("red_data", data, 16'h001F);
        send_seq(H + 1, N - H - 1, 0);
        idle_tick();

        // Restart mid-frame at pixel 40.
        d0 = n_done;
        send_seq(0, 40, 1);
        send_pix(1, 0, 5'h03, 6'h05, 5'h07);
        chk("restart_err_sof", err_sof, 1);
        chk("restart_addr", addr, 0);
        send_seq(1, N - 1, 0);
        chk("restart_one_done", n_done - d0, 1);
        send_seq(0, N, 1);
        chk("restart_next_done", n_done - d0, 2);
        clr = 1;
        idle_tick();
        clr = 0;
        chk("sof_clr", err_sof, 0);

        // Early eol at x=5 on line 3.
        send_seq(0, 3 * H + 5, 1);
        send_pix(0, 1, 5'h01, 6'h02, 5'h03);
        chk("eol_err_line", err_line, 1);
        send_pix(0, 0, 5'h04, 6'h05, 5'h06);
        chk("eol_realign_addr", addr, 4 * H);
        clr = 1;
        idle_tick();
        clr = 0;
        chk("line_clr", err_line, 0);
        send_seq(4 * H + 1, 2 * H - 1, 0);
        idle_tick();
        // Error set in the same cycle as a clear: set wins.
        clr = 1;
        send_pix(1, 1, 5'h0A, 6'h0B, 5'h0C);
        clr = 0;
        chk("set_wins", err_line, 1);
        send_seq(H, N - H, 0);
        idle_tick();

        // Random gaps; first frame disabled, second enabled with en_i wandering mid-frame.
        gap_pct = 40;
        en = 0;
        w0 = n_wr;
        send_seq(0, N, 1);
        chk("disabled_no_writes", n_wr - w0, 0);
        en = 1; en_rand = 1;
        w0 = n_wr; d0 = n_done; nr0 = n_nrdy;
        send_seq(0, N, 1);
        en_rand = 0; en = 1; gap_pct = 0;
        repeat (2) idle_tick();
        chk("gap_writes", n_wr - w0, N);
        chk("gap_done", n_done - d0, 1);
        chk("gap_ready_low", n_nrdy - nr0, 1);

        // Reset mid-frame.
        send_seq(0, 50, 1);
        rst = 1;
        idle_tick();
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_err", {err_sof, err_line}, 0);
        chk("mid_rst_addr", addr, 0);
        idle_tick();
        rst = 0;
        w0 = n_wr;
        send_seq(51, 10, 0);
        chk("post_rst_discard", n_wr - w0, 0);
        send_seq(0, N, 1);
        chk("post_rst_cnt", cnt, 1);

        // Frame counter wraps 255 -> 0.
        for (int f = 0; f < 255; f++) send_seq(0, N, 1);
        chk("cnt_wrap", cnt, 0);
        idle_tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
